// File: rtl/alu_seq_pkg.sv
// Types and opcode helpers for the wide-operation sequencer in front of the byte ALU.
`include "defines.sv"

package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = `ADD_FN;
    localparam logic [3:0] OP_ADDC = `ADDC_FN;
    localparam logic [3:0] OP_SUB  = `SUB_FN;
    localparam logic [3:0] OP_SUBC = `SUBC_FN;
    localparam logic [3:0] OP_AND  = `AND_FN;
    localparam logic [3:0] OP_OR   = `OR_FN;
    localparam logic [3:0] OP_XOR  = `XOR_FN;
    localparam logic [3:0] OP_MASK = `MASK_FN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_supported(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
            OP_AND, OP_OR, OP_XOR, OP_MASK: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Arithmetic ops chain carry/borrow between bytes; logic ops do not.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDC) || (op == OP_SUB) || (op == OP_SUBC);
    endfunction

    function automatic logic uses_cin(input logic [3:0] op);
        return (op == OP_ADDC) || (op == OP_SUBC);
    endfunction

    function automatic logic [3:0] byte_opcode(input logic [3:0] op, input logic first_byte);
        if (!first_byte && op == OP_ADD) return OP_ADDC;
        if (!first_byte && op == OP_SUB) return OP_SUBC;
        return op;
    endfunction

endpackage

// File: rtl/defines.sv
// Function codes shared by the 8-bit ALU and the units that drive it.
`ifndef ALU_DEFINES_SV
`define ALU_DEFINES_SV
`define ADD_FN  4'h0
`define ADDC_FN 4'h1
`define SUB_FN  4'h2
`define SUBC_FN 4'h3
`define AND_FN  4'h4
`define OR_FN   4'h5
`define XOR_FN  4'h6
`define MASK_FN 4'h7
`endif

// File: rtl/alu_wide_seq.sv
// Drives an NBYTES-wide operation through the 8-bit ALU one byte per cycle, LSB first,
// chaining carry/borrow and folding the per-byte zero flags into a registered wide result.
module alu_wide_seq
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [3:0]            i_op,
    input  logic [8*NBYTES-1:0]   i_a,
    input  logic [8*NBYTES-1:0]   i_b,
    input  logic                  i_cin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [8*NBYTES-1:0]   o_result,
    output logic                  o_cout,
    output logic                  o_zero,
    output logic [7:0]            o_alu_in1,
    output logic [7:0]            o_alu_in2,
    output logic [3:0]            o_alu_opcode,
    output logic                  o_alu_cin,
    input  logic [7:0]            i_alu_out,
    input  logic                  i_alu_cout,
    input  logic                  i_alu_z
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [3:0]        r_op;
    logic              r_carry;
    logic              r_zacc;
    logic [W-1:0]      r_work;
    logic [W-1:0]      r_result;
    logic              r_cout;
    logic              r_zero;
    logic              r_err;

    logic              w_supported;
    logic              w_last;
    logic [W-1:0]      w_work_next;

    assign w_supported = is_supported(i_op);
    assign w_last      = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every variable assigned in a combinational block gets a default first,
    // so no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = w_supported ? RUN : DONE;
            RUN:     if (w_last)  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Wide results are assembled in r_work so o_result only changes when an operation completes.
    always_comb begin
        w_work_next = r_work;
        w_work_next[{r_idx, 3'b000} +: 8] = i_alu_out;
    end

    // NOTE: operand/opcode latches carry no reset; they are only read in RUN, after a load.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && i_start && w_supported) begin
            r_a  <= i_a;
            r_b  <= i_b;
            r_op <= i_op;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its sources, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b0;
            r_work   <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_idx   <= '0;
                        r_carry <= w_supported && uses_cin(i_op) && i_cin;
                        r_zacc  <= 1'b1;
                        r_err   <= !w_supported;
                    end
                end
                RUN: begin
                    r_work <= w_work_next;
                    r_zacc <= r_zacc & i_alu_z;
                    if (is_arith(r_op)) r_carry <= i_alu_cout;
                    if (w_last) begin
                        r_result <= w_work_next;
                        r_cout   <= is_arith(r_op) && i_alu_cout;
                        r_zero   <= r_zacc & i_alu_z;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ALU drive comes only from registered state, so start/a/b never reach the ALU in the same cycle.
    always_comb begin
        o_alu_in1    = '0;
        o_alu_in2    = '0;
        o_alu_cin    = 1'b0;
        o_alu_opcode = OP_ADD;
        if (r_state == RUN) begin
            o_alu_in1    = r_a[{r_idx, 3'b000} +: 8];
            o_alu_in2    = r_b[{r_idx, 3'b000} +: 8];
            o_alu_cin    = r_carry;
            o_alu_opcode = byte_opcode(r_op, r_idx == '0);
        end
    end

    assign o_busy   = (r_state != IDLE);
    assign o_done   = (r_state == DONE);
    assign o_err    = o_done & r_err;
    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_zero   = r_zero;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq with a behavioural 8-bit ALU attached.
module tb_alu_wide_seq;
    import alu_seq_pkg::*;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        cin;
    logic        busy, done, err;
    logic [31:0] result;
    logic        cout, zero;
    logic [7:0]  alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_opcode;
    logic        alu_cin, alu_cout, alu_z;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        co, z, e;
        int          lat, bc;
        logic        d_after, b_after;
    } obs_t;

    alu_wide_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b), .i_cin(cin),
        .o_busy(busy), .o_done(done), .o_err(err), .o_result(result), .o_cout(cout), .o_zero(zero),
        .o_alu_in1(alu_in1), .o_alu_in2(alu_in2), .o_alu_opcode(alu_opcode), .o_alu_cin(alu_cin),
        .i_alu_out(alu_out), .i_alu_cout(alu_cout), .i_alu_z(alu_z)
    );

    always #5 clk = ~clk;

    // Byte ALU: 9-bit arithmetic, bit 8 is carry (add) or borrow (sub).
    logic [8:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (alu_opcode)
            OP_ADD:  alu_t = {1'b0, alu_in1} + {1'b0, alu_in2};
            OP_ADDC: alu_t = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'b0, alu_cin};
            OP_SUB:  alu_t = {1'b0, alu_in1} - {1'b0, alu_in2};
            OP_SUBC: alu_t = {1'b0, alu_in1} - {1'b0, alu_in2} - {8'b0, alu_cin};
            OP_AND:  alu_t = {1'b0, alu_in1 & alu_in2};
            OP_OR:   alu_t = {1'b0, alu_in1 | alu_in2};
            OP_XOR:  alu_t = {1'b0, alu_in1 ^ alu_in2};
            OP_MASK: alu_t = {1'b0, ~(alu_in1 & alu_in2)};
            default: alu_t = '0;
        endcase
    end
    assign alu_out  = alu_t[7:0];
    assign alu_cout = alu_t[8];
    assign alu_z    = (alu_t[7:0] == 8'h00);

    // Whole-word reference: what the wide operation means, independent of byte slicing.
    function automatic void ref_model(input logic [3:0] o, input logic [31:0] x, y, input logic c,
                                      output logic [31:0] r, output logic co);
        logic [32:0] t;
        co = 1'b0;
        r  = '0;
        case (o)
            OP_ADD:  begin t = {1'b0, x} + {1'b0, y}; r = t[31:0]; co = t[32]; end
            OP_ADDC: begin t = {1'b0, x} + {1'b0, y} + {32'b0, c}; r = t[31:0]; co = t[32]; end
            OP_SUB:  begin r = x - y; co = (x < y); end
            OP_SUBC: begin r = x - y - {31'b0, c}; co = ({1'b0, x} < ({1'b0, y} + {32'b0, c})); end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_MASK: r = ~(x & y);
            default: r = '0;
        endcase
    endfunction

    task automatic launch(input logic [3:0] o, input logic [31:0] x, y, input logic c);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; cin = c;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); op = 4'($urandom_range(0, 15));
    endtask

    // k0 = edges already elapsed since the accepting edge; lat = edges from acceptance to done.
    task automatic wait_done(input int k0, output obs_t ob);
        int k = k0;
        bit got = 0;
        ob.lat = -1; ob.bc = k0; ob.res = 'x; ob.co = 1'bx; ob.z = 1'bx; ob.e = 1'bx;
        while (!got && k < 20) begin
            if (busy) ob.bc++;
            if (done) begin
                got = 1; ob.lat = k; ob.res = result; ob.co = cout; ob.z = zero; ob.e = err;
            end else begin
                @(posedge clk); #1; k++;
            end
        end
        @(posedge clk); #1;
        ob.d_after = done; ob.b_after = busy;
    endtask

    task automatic do_op(input logic [3:0] o, input logic [31:0] x, y, input logic c, output obs_t ob);
        launch(o, x, y, c);
        wait_done(0, ob);
    endtask

    task automatic expect_op(input string nm, input logic [3:0] o, input logic [31:0] x, y, input logic c,
                             input logic [31:0] er, input logic eco, input logic ez);
        obs_t ob;
        do_op(o, x, y, c, ob);
        n_checks++; if (ob.lat !== NB) begin n_errors++; $display("FAIL %s latency got=%0d exp=%0d", nm, ob.lat, NB); end
        n_checks++; if (ob.res !== er) begin n_errors++; $display("FAIL %s result got=%h exp=%h", nm, ob.res, er); end
        n_checks++; if (ob.co !== eco) begin n_errors++; $display("FAIL %s cout got=%b exp=%b", nm, ob.co, eco); end
        n_checks++; if (ob.z !== ez) begin n_errors++; $display("FAIL %s zero got=%b exp=%b", nm, ob.z, ez); end
        n_checks++; if (ob.e !== 1'b0) begin n_errors++; $display("FAIL %s err got=%b exp=0", nm, ob.e); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = OP_ADD; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({busy, done, err, cout, zero} !== 5'b0) begin n_errors++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, err, cout, zero}); end
        n_checks++; if (result !== 32'h0) begin n_errors++; $display("FAIL reset_result got=%h exp=0", result); end
        n_checks++; if ({alu_in1, alu_in2, alu_opcode, alu_cin} !== {8'h0, 8'h0, OP_ADD, 1'b0}) begin
            n_errors++; $display("FAIL reset_alu_drive got=%h/%h/%h/%b exp=0/0/%h/0", alu_in1, alu_in2, alu_opcode, alu_cin, OP_ADD);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        obs_t ob;
        do_op(OP_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b0, ob);
        n_checks++; if (ob.lat !== NB) begin n_errors++; $display("FAIL add_latency got=%0d exp=%0d", ob.lat, NB); end
        n_checks++; if (ob.bc !== NB + 1) begin n_errors++; $display("FAIL add_busy_cycles got=%0d exp=%0d", ob.bc, NB + 1); end
        n_checks++; if (ob.res !== 32'h0000_0100 || ob.co !== 1'b0 || ob.z !== 1'b0) begin
            n_errors++; $display("FAIL add_carry_chain got=%h/%b/%b exp=00000100/0/0", ob.res, ob.co, ob.z);
        end
        n_checks++; if (ob.d_after !== 1'b0 || ob.b_after !== 1'b0) begin
            n_errors++; $display("FAIL add_done_pulse got done=%b busy=%b exp=0/0", ob.d_after, ob.b_after);
        end
        expect_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1);
        expect_op("addc_cin", OP_ADDC, 32'h0, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0);
        expect_op("add_ignores_cin", OP_ADD, 32'h1, 32'h1, 1'b1, 32'h2, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        expect_op("sub_borrow", OP_SUB, 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        expect_op("subc_cin", OP_SUBC, 32'h10, 32'h0F, 1'b1, 32'h0, 1'b0, 1'b1);
        expect_op("sub_ignores_cin", OP_SUB, 32'h5, 32'h3, 1'b1, 32'h2, 1'b0, 1'b0);
    endtask

    task automatic test_logic();
        expect_op("xor_zero", OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'h0, 1'b0, 1'b1);
        expect_op("mask", OP_MASK, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 32'h00FF_FFFF, 1'b0, 1'b0);
        expect_op("or", OP_OR, 32'h1200_0034, 32'h0056_7800, 1'b0, 32'h1256_7834, 1'b0, 1'b0);
    endtask

    // Per-byte ALU drive: carry into byte k is the carry/borrow out of the low k bytes.
    task automatic test_alu_drive();
        logic [3:0]  ops [2] = '{OP_ADDC, OP_SUB};
        for (int t = 0; t < 2; t++) begin
            logic [31:0] x = $urandom, y = $urandom;
            logic        c = 1'b1;
            obs_t        ob;
            launch(ops[t], x, y, c);
            for (int k = 0; k < NB; k++) begin
                logic [31:0] m = (k == 0) ? 32'h0 : ((32'h1 << (8 * k)) - 32'h1);
                logic [32:0] s = {1'b0, x & m} + {1'b0, y & m} + {32'b0, c};
                logic        ec = (ops[t] == OP_ADDC) ? s[8 * k] : ((x & m) < (y & m));
                logic [3:0]  eo = (ops[t] == OP_SUB && k > 0) ? OP_SUBC : ops[t];
                logic [31:0] xs = x >> (8 * k), ys = y >> (8 * k);
                n_checks++; if ({alu_opcode, alu_in1, alu_in2, alu_cin} !== {eo, xs[7:0], ys[7:0], ec}) begin
                    n_errors++;
                    $display("FAIL alu_drive op=%h byte=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", ops[t], k,
                             alu_opcode, alu_in1, alu_in2, alu_cin, eo, xs[7:0], ys[7:0], ec);
                end
                @(posedge clk); #1;
            end
            n_checks++; if ({done, alu_in1, alu_in2, alu_opcode, alu_cin} !== {1'b1, 8'h0, 8'h0, OP_ADD, 1'b0}) begin
                n_errors++; $display("FAIL alu_drive_done got done=%b drive=%h/%h/%h/%b exp=1 0/0/%h/0", done, alu_in1, alu_in2, alu_opcode, alu_cin, OP_ADD);
            end
            wait_done(NB, ob);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [8] = '{OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_MASK};
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  o = ops[$urandom_range(0, 7)];
            logic [31:0] x = $urandom, y = (i % 5 == 0) ? x : $urandom;
            logic        c = 1'($urandom_range(0, 1));
            logic [31:0] er;
            logic        eco;
            obs_t        ob;
            ref_model(o, x, y, c, er, eco);
            do_op(o, x, y, c, ob);
            n_checks++; if ({ob.res, ob.co, ob.z, ob.e} !== {er, eco, er == 32'h0, 1'b0} || ob.lat !== NB) begin
                n_errors++;
                $display("FAIL random op=%h a=%h b=%h cin=%b got=%h/%b/%b/%b lat=%0d exp=%h/%b/%b/0 lat=%0d",
                         o, x, y, c, ob.res, ob.co, ob.z, ob.e, ob.lat, er, eco, er == 32'h0, NB);
            end
            n_checks++; if (result !== er) begin n_errors++; $display("FAIL random_hold got=%h exp=%h", result, er); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t ob;
        bit   extra = 0;
        launch(OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0);
        @(negedge clk); start = 1'b1; op = OP_SUB; a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(1, ob);
        n_checks++; if (ob.res !== 32'h3333_3333 || ob.co !== 1'b0 || ob.lat !== NB) begin
            n_errors++; $display("FAIL busy_start_ignored got=%h/%b lat=%0d exp=33333333/0 lat=%0d", ob.res, ob.co, ob.lat, NB);
        end
        repeat (2 * NB) begin @(posedge clk); #1; if (done || busy) extra = 1; end
        n_checks++; if (extra !== 1'b0) begin n_errors++; $display("FAIL busy_start_not_queued got=%b exp=0", extra); end
        for (int i = 0; i < 2; i++) begin
            logic [3:0] bad = (i == 0) ? 4'hF : 4'h9;
            do_op(bad, 32'h0, 32'h0, 1'b0, ob);
            n_checks++; if (ob.lat !== 0 || ob.e !== 1'b1) begin
                n_errors++; $display("FAIL unsupported_err op=%h got lat=%0d err=%b exp lat=0 err=1", bad, ob.lat, ob.e);
            end
            n_checks++; if ({ob.res, ob.co, ob.z} !== {32'h3333_3333, 1'b0, 1'b0} || ob.d_after !== 1'b0) begin
                n_errors++; $display("FAIL unsupported_hold got=%h/%b/%b done_after=%b exp=33333333/0/0 0", ob.res, ob.co, ob.z, ob.d_after);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t ob;
        bit   seen = 0;
        expect_op("pre_reset_add", OP_ADD, 32'h5, 32'h6, 1'b0, 32'hB, 1'b0, 1'b0);
        launch(OP_ADD, 32'h0101_0101, 32'h0202_0202, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({busy, done, err, cout, zero, result} !== 37'h0) begin
            n_errors++; $display("FAIL reset_mid_outputs got=%b%b%b%b%b/%h exp=00000/00000000", busy, done, err, cout, zero, result);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (NB + 2) begin @(posedge clk); #1; if (done) seen = 1; end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL reset_mid_no_done got=%b exp=0", seen); end
        do_op(OP_ADD, 32'h1, 32'h1, 1'b0, ob);
        n_checks++; if (ob.res !== 32'h2 || ob.lat !== NB) begin
            n_errors++; $display("FAIL reset_mid_recover got=%h lat=%0d exp=00000002 lat=%0d", ob.res, ob.lat, NB);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_alu_drive();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
